dbus_peri_initiator: RTL and testbench
======================================

// Module: dbus_peri_initiator
// PURPOSE
// - Initiator end of the peripheral data bus. Accepts one load/store at a time from the core LSU.
// - Decodes the peripheral window into one-hot selects for GPIO A/B/C, switches and LEDs.
// - Drives the request onto the flat bus fields, which the top level packs into type_dbus2peri_s.
// - Waits for the responder ack, unpacked from type_peri2dbus_s, then returns rdata and status to the LSU.
// PARAMETERS
// - PERI_BASE       32'h8000_0000  peripheral window base; addr[31:12] is compared against PERI_BASE[31:12]
// - TIMEOUT_CYCLES  16             max WAIT cycles before a bus error (only with DBUS_TIMEOUT_EN); legal range 2..255
// PORTS
// - clk           in   1   system clock
// - rst           in   1   synchronous, active-high reset
// - cpu_req_i     in   1   LSU request valid
// - cpu_we_i      in   1   1 = store, 0 = load
// - cpu_addr_i    in   32  byte address
// - cpu_wdata_i   in   32  store data
// - cpu_be_i      in   4   byte enables
// - cpu_ready_o   out  1   block idle; request accepted when cpu_req_i & cpu_ready_o
// - cpu_rvalid_o  out  1   one-cycle completion pulse (loads and stores)
// - cpu_rdata_o   out  32  load data; valid only with cpu_rvalid_o
// - cpu_err_o     out  1   decode miss or timeout; valid only with cpu_rvalid_o
// - peri_req_o    out  1   bus request, held until ack or timeout
// - peri_we_o     out  1   registered copy of cpu_we_i
// - peri_addr_o   out  8   register offset, addr[7:0]
// - peri_wdata_o  out  32  registered store data
// - peri_be_o     out  4   registered byte enables
// - gpioA_sel_o / gpioB_sel_o / gpioC_sel_o / gpsw_sel_o / gpled_sel_o  out  1 each  one-hot selects, asserted only with peri_req_o
// - peri_ack_i    in   1   responder ack; rdata is valid in the same cycle
// - peri_rdata_i  in   32  responder read data
// BEHAVIOUR
// - Reset values: cpu_ready_o = 1; every other output = 0; FSM goes to IDLE; timeout counter = 0.
// - Decode on addr[11:8]: 0 = gpioA, 1 = gpioB, 2 = gpioC, 3 = gpsw, 4 = gpled. Other values, or a window miss, are a decode error.
// - IDLE: cpu_ready_o = 1. On accept, register we/addr/wdata/be and the select.
//   - Hit -> REQ.
//   - Miss -> RESP with err = 1 and rdata = 0; no bus activity.
// - REQ (one cycle): peri_req_o = 1 with the select; counter cleared. Ack this cycle -> RESP, else -> WAIT.
// - WAIT: peri_req_o and select held; all bus fields stay stable. On ack, capture peri_rdata_i (0 for stores) -> RESP.
// - RESP: cpu_rvalid_o = 1 for exactly one cycle; peri_req_o = 0; all selects = 0; then -> IDLE.
// - cpu_ready_o = 0 in REQ, WAIT and RESP. A new request can be accepted the cycle after RESP.
// - Latency: accept at edge N; peri_req_o high during cycle N+1; ack after k wait cycles (k >= 0); cpu_rvalid_o high in cycle N+2+k.
//   - Back-to-back minimum is 3 cycles per access.
//   - A decode miss completes with cpu_rvalid_o in cycle N+1.
// - peri_ack_i seen in IDLE or RESP is ignored; no state change, no data captured.
// - cpu_req_i while not ready is ignored; the LSU holds the request.
// - cpu_rdata_o and cpu_err_o hold their values after the rvalid pulse until the next completion.
// - Reset mid-transaction: at the reset edge peri_req_o and the selects drop, the FSM returns to IDLE, and no rvalid is issued.
// CONFIGURATION
// - DBUS_TIMEOUT_EN defined:
//   - 8-bit counter increments each WAIT cycle.
//   - When it reaches TIMEOUT_CYCLES-1 with no ack: drop peri_req_o -> RESP with err = 1 and rdata = 0.
//   - Ack in the expiry cycle wins: normal completion with err = 0.
// - DBUS_TIMEOUT_EN undefined: no counter; WAIT lasts until ack, possibly forever; cpu_err_o is set only by decode misses.
// TESTING
// - Reset, then load 0x8000_0104 with ack on the first REQ cycle, rdata 0x0000_00A5:
//   - gpioB_sel_o = 1 for one cycle, peri_addr_o = 0x04;
//   - cpu_rvalid_o two cycles after accept with rdata 0xA5 and err 0.
// - Store 0x8000_0400, wdata 0x0000_FFFF, be 4'b0011, ack delayed 3 cycles:
//   - gpled_sel_o, peri_we_o and the bus fields stable for 4 cycles;
//   - rvalid in cycle N+5, err 0.
// - Load 0x8000_0700 (bad index) and load 0x9000_0000 (window miss):
//   - no peri_req_o;
//   - rvalid in cycle N+1 with err 1 and rdata 0.
// - DBUS_TIMEOUT_EN, TIMEOUT_CYCLES = 16, never ack: rvalid with err 1 after 16 WAIT cycles. Repeat with ack in the expiry cycle: err 0 with data.
// - Assert rst in the 2nd WAIT cycle of a gpioC load: peri_req_o and gpioC_sel_o low the next cycle, cpu_ready_o = 1, no rvalid; a later request works normally.
// - Spurious peri_ack_i while IDLE, plus cpu_req_i held during WAIT: no extra rvalid; exactly one completion per accepted request.

Source files
------------

// File: rtl/dbus_peri_initiator_if.sv
// rtl/dbus_peri_initiator_if.sv - flat peripheral data bus between the initiator and the GPIO/switch/LED responders
//
// Signals (initiator view, modport master):
//   peri_req    out  1   bus request, held until ack or timeout
//   peri_we     out  1   1 = store, 0 = load
//   peri_addr   out  8   register offset inside the selected responder
//   peri_wdata  out  32  store data
//   peri_be     out  4   byte enables
//   gpio_a_sel  out  1   one-hot responder selects, only asserted with peri_req
//   gpio_b_sel  out  1
//   gpio_c_sel  out  1
//   gpsw_sel    out  1
//   gpled_sel   out  1
//   peri_ack    in   1   responder ack, peri_rdata valid in the same cycle
//   peri_rdata  in   32  responder read data
// The responder side (modport slave) sees the same signals with directions flipped.

interface dbus_peri_initiator_if;

  logic        peri_req;
  logic        peri_we;
  logic [7:0]  peri_addr;
  logic [31:0] peri_wdata;
  logic [3:0]  peri_be;
  logic        gpio_a_sel;
  logic        gpio_b_sel;
  logic        gpio_c_sel;
  logic        gpsw_sel;
  logic        gpled_sel;
  logic        peri_ack;
  logic [31:0] peri_rdata;

  modport master (
    output peri_req,
    output peri_we,
    output peri_addr,
    output peri_wdata,
    output peri_be,
    output gpio_a_sel,
    output gpio_b_sel,
    output gpio_c_sel,
    output gpsw_sel,
    output gpled_sel,
    input  peri_ack,
    input  peri_rdata
  );

  modport slave (
    input  peri_req,
    input  peri_we,
    input  peri_addr,
    input  peri_wdata,
    input  peri_be,
    input  gpio_a_sel,
    input  gpio_b_sel,
    input  gpio_c_sel,
    input  gpsw_sel,
    input  gpled_sel,
    output peri_ack,
    output peri_rdata
  );

endinterface

// File: rtl/dbus_peri_initiator.sv
// rtl/dbus_peri_initiator.sv - initiator end of the peripheral data bus, one LSU access at a time
//
// Purpose:
//   Accepts a single load/store from the core LSU, decodes the peripheral
//   window into one-hot responder selects, drives the request onto the flat
//   peripheral bus, waits for the responder ack and returns read data and
//   status to the LSU with a one-cycle completion pulse.
//
// Parameters:
//   PERI_BASE       peripheral window base; addr[31:12] compared against PERI_BASE[31:12]
//   TIMEOUT_CYCLES  WAIT cycles before a bus error when the timeout is built in (2..255)
//
// Optional feature:
//   DBUS_TIMEOUT_EN  when defined, an 8-bit counter aborts an unanswered
//                    access with err = 1; when undefined WAIT lasts until ack.
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous, active-high reset
//   cpu_req_i     in   1   LSU request valid
//   cpu_we_i      in   1   1 = store, 0 = load
//   cpu_addr_i    in   32  byte address
//   cpu_wdata_i   in   32  store data
//   cpu_be_i      in   4   byte enables
//   cpu_ready_o   out  1   idle; request accepted when cpu_req_i & cpu_ready_o
//   cpu_rvalid_o  out  1   one-cycle completion pulse
//   cpu_rdata_o   out  32  load data, held until the next completion
//   cpu_err_o     out  1   decode miss or timeout, held until the next completion
//   bus           master   peripheral bus (see dbus_peri_initiator_if)

module dbus_peri_initiator #(
  parameter logic [31:0] PERI_BASE      = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req_i,
  input  logic                        cpu_we_i,
  input  logic [31:0]                 cpu_addr_i,
  input  logic [31:0]                 cpu_wdata_i,
  input  logic [3:0]                  cpu_be_i,
  output logic                        cpu_ready_o,
  output logic                        cpu_rvalid_o,
  output logic [31:0]                 cpu_rdata_o,
  output logic                        cpu_err_o,
  dbus_peri_initiator_if.master       bus
);

  // Elaboration guard: the timeout counter is 8 bits wide and needs at
  // least one WAIT cycle before expiry.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Select vector bit order: {gpled, gpsw, gpioC, gpioB, gpioA}
  localparam int SEL_W = 5;

  logic [1:0]       state;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             window_hit;
  logic [SEL_W-1:0] dec_sel;
  logic             bus_active;

`ifdef DBUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
`endif

  // ------------------------------------------------------------------
  // Address decode of the incoming LSU request
  // ------------------------------------------------------------------
  assign window_hit = (cpu_addr_i[31:12] == PERI_BASE[31:12]);

  always_comb begin
    dec_sel = '0;
    if (window_hit) begin
      case (cpu_addr_i[11:8])
        4'd0:    dec_sel = 5'b00001;
        4'd1:    dec_sel = 5'b00010;
        4'd2:    dec_sel = 5'b00100;
        4'd3:    dec_sel = 5'b01000;
        4'd4:    dec_sel = 5'b10000;
        default: dec_sel = '0;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Transaction FSM and registered bus fields
  // ------------------------------------------------------------------
  // Bus fields are only written on accept, so they stay stable for the
  // whole REQ/WAIT phase without extra hold logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req_i) begin
            we_q    <= cpu_we_i;
            addr_q  <= cpu_addr_i[7:0];
            wdata_q <= cpu_wdata_i;
            be_q    <= cpu_be_i;
            sel_q   <= dec_sel;
            if (|dec_sel) begin
              state <= ST_REQ;
            end else begin
              // Decode miss completes locally; nothing goes on the bus.
              state   <= ST_RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end

        ST_REQ: begin
`ifdef DBUS_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (bus.peri_ack) begin
            state   <= ST_RESP;
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : bus.peri_rdata;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Ack is checked first so an ack in the expiry cycle still
          // completes normally.
          if (bus.peri_ack) begin
            state   <= ST_RESP;
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : bus.peri_rdata;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_LAST) begin
            state   <= ST_RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus_active = (state == ST_REQ) || (state == ST_WAIT);

  assign cpu_ready_o  = (state == ST_IDLE);
  assign cpu_rvalid_o = (state == ST_RESP);
  assign cpu_rdata_o  = rdata_q;
  assign cpu_err_o    = err_q;

  assign bus.peri_req   = bus_active;
  assign bus.peri_we    = we_q;
  assign bus.peri_addr  = addr_q;
  assign bus.peri_wdata = wdata_q;
  assign bus.peri_be    = be_q;

  // Selects are gated by the request so they fall together with it in
  // RESP, on timeout and on reset.
  assign bus.gpio_a_sel = sel_q[0] & bus_active;
  assign bus.gpio_b_sel = sel_q[1] & bus_active;
  assign bus.gpio_c_sel = sel_q[2] & bus_active;
  assign bus.gpsw_sel   = sel_q[3] & bus_active;
  assign bus.gpled_sel  = sel_q[4] & bus_active;

endmodule

// File: tb/tb_dbus_peri_initiator.sv
// tb/tb_dbus_peri_initiator.sv - scoreboard testbench for dbus_peri_initiator

module tb_dbus_peri_initiator;

  localparam int TIMEOUT_CYCLES = 16;
`ifdef DBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [3:0]  cpu_be_i = '0;
  logic        cpu_ready_o;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        cpu_err_o;

  dbus_peri_initiator_if pbus ();

  dbus_peri_initiator #(
    .PERI_BASE      (32'h8000_0000),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_be_i     (cpu_be_i),
    .cpu_ready_o  (cpu_ready_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_err_o    (cpu_err_o),
    .bus          (pbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rv_count = 0;

  // Responder model: acks resp_delay cycles after the first request cycle
  // (-1 = never); spurious forces ack while no request is on the bus.
  int          resp_delay = -1;
  logic [31:0] resp_data = '0;
  logic        spurious = 1'b0;
  int          ack_cyc = 0;
  logic        req_prev = 1'b0;

  always @(negedge clk) begin
    if (pbus.peri_req === 1'b1) begin
      ack_cyc = req_prev ? ack_cyc + 1 : 0;
      pbus.peri_ack = (ack_cyc == resp_delay);
      pbus.peri_rdata = (ack_cyc == resp_delay) ? resp_data : 32'hDEAD_BEEF;
    end else begin
      pbus.peri_ack = spurious;
      pbus.peri_rdata = spurious ? 32'hBAD0_BAD0 : 32'd0;
    end
    req_prev = (pbus.peri_req === 1'b1);
  end

  always @(posedge clk) begin
    #1;
    if (cpu_rvalid_o === 1'b1) rv_count++;
  end

  function automatic logic [4:0] model_sel(input logic [31:0] a);
    logic [4:0] s;
    s = '0;
    if (a[31:12] == 20'h80000 && a[11:8] < 4'd5) s = 5'b00001 << a[10:8];
    return s;
  endfunction

  function automatic logic [4:0] sel_now();
    return {pbus.gpled_sel, pbus.gpsw_sel, pbus.gpio_c_sel, pbus.gpio_b_sel, pbus.gpio_a_sel};
  endfunction

  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int delay, input logic [31:0] data,
                            input bit hold);
    exp_t        e;
    exp_t        got;
    logic [4:0]  esel;
    logic [78:0] bus_exp;
    logic [78:0] bus_act;
    int          lat;
    int          reqs;
    bit          done;
    esel = model_sel(addr);
    if (esel == 5'd0) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1; e.reqs = 0;
    end else if (delay >= 0 && (!TO_EN || delay <= TIMEOUT_CYCLES)) begin
      e.rdata = we ? 32'd0 : data; e.err = 1'b0; e.lat = 2 + delay; e.reqs = delay + 1;
    end else begin
      e.rdata = '0; e.err = 1'b1; e.lat = 2 + TIMEOUT_CYCLES; e.reqs = TIMEOUT_CYCLES + 1;
    end
    @(negedge clk);
    vectors++;
    if (cpu_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_req: got %b want 1", cpu_ready_o);
    end
    resp_delay = delay;
    resp_data = data;
    cpu_we_i = we;
    cpu_addr_i = addr;
    cpu_wdata_i = wdata;
    cpu_be_i = be;
    cpu_req_i = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) cpu_req_i = 1'b0;
    bus_exp = {1'b1, esel, we, addr[7:0], wdata, be, 28'd0};
    lat = 1;
    reqs = 0;
    done = 1'b0;
    while (!done && lat <= 60) begin
      if (cpu_rvalid_o === 1'b1) begin
        done = 1'b1;
        if (hold) cpu_req_i = 1'b0;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rvalid: got rvalid want no completion pending");
        end else begin
          got = sb_q.pop_front();
          if (cpu_rdata_o !== got.rdata || cpu_err_o !== got.err || lat != got.lat || reqs != got.reqs) begin
            miscompares++;
            $display("FAIL completion %h: got rdata=%h err=%b lat=%0d reqs=%0d want rdata=%h err=%b lat=%0d reqs=%0d",
                     addr, cpu_rdata_o, cpu_err_o, lat, reqs, got.rdata, got.err, got.lat, got.reqs);
          end
        end
      end else begin
        if (pbus.peri_req === 1'b1) reqs++;
        vectors++;
        if (esel != 5'd0) begin
          bus_act = {pbus.peri_req, sel_now(), pbus.peri_we, pbus.peri_addr, pbus.peri_wdata, pbus.peri_be, 28'd0};
          if (bus_act !== bus_exp) begin
            miscompares++;
            $display("FAIL bus_fields %h cycle %0d: got %h want %h", addr, lat, bus_act, bus_exp);
          end
        end else if ({pbus.peri_req, sel_now()} !== 6'd0) begin
          miscompares++;
          $display("FAIL miss_no_bus %h: got req/sel %b want 000000", addr, {pbus.peri_req, sel_now()});
        end
        @(negedge clk);
        lat++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      cpu_req_i = 1'b0;
      $display("FAIL completion_timeout %h: got no rvalid in 60 cycles want rvalid", addr);
    end else begin
      @(negedge clk);
      vectors++;
      if (cpu_rvalid_o !== 1'b0 || cpu_rdata_o !== e.rdata || cpu_err_o !== e.err) begin
        miscompares++;
        $display("FAIL hold_after_rvalid: got rvalid=%b rdata=%h err=%b want 0 %h %b",
                 cpu_rvalid_o, cpu_rdata_o, cpu_err_o, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cpu_ready_o, cpu_rvalid_o, cpu_rdata_o, cpu_err_o} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_cpu: got ready=%b rvalid=%b rdata=%h err=%b want 1 0 0 0",
               cpu_ready_o, cpu_rvalid_o, cpu_rdata_o, cpu_err_o);
    end
    vectors++;
    if ({pbus.peri_req, sel_now(), pbus.peri_we, pbus.peri_addr, pbus.peri_wdata, pbus.peri_be} !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got req=%b sel=%b we=%b addr=%h wdata=%h be=%h want all 0",
               pbus.peri_req, sel_now(), pbus.peri_we, pbus.peri_addr, pbus.peri_wdata, pbus.peri_be);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_gpiob();
    run_access(1'b0, 32'h8000_0104, 32'h0, 4'hF, 0, 32'h0000_00A5, 1'b0);
  endtask

  task automatic test_store_gpled();
    run_access(1'b1, 32'h8000_0400, 32'h0000_FFFF, 4'b0011, 3, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_decode_miss();
    run_access(1'b0, 32'h8000_0700, 32'h0, 4'hF, 0, 32'h1111_1111, 1'b0);
    run_access(1'b0, 32'h9000_0000, 32'h0, 4'hF, 0, 32'h2222_2222, 1'b0);
  endtask

  task automatic test_all_selects();
    for (int i = 0; i < 5; i++) begin
      run_access(i[0], 32'h8000_0000 | (32'(i) << 8) | 32'($urandom_range(0, 255)),
                 $urandom, 4'($urandom_range(1, 15)), i % 3, $urandom, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    int   accepts;
    int   rvs;
    int   last_rv;
    bit   pending;
    e.rdata = 32'h5A5A_0001; e.err = 1'b0; e.lat = 2; e.reqs = 1;
    @(negedge clk);
    resp_delay = 0;
    resp_data = 32'h5A5A_0001;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h8000_0008;
    cpu_be_i = 4'hF;
    cpu_req_i = 1'b1;
    accepts = 0; rvs = 0; last_rv = -1; pending = 1'b0;
    for (int c = 0; c < 40 && rvs < 3; c++) begin
      if (pending) begin accepts++; pending = 1'b0; end
      if (accepts == 3) cpu_req_i = 1'b0;
      if (cpu_rvalid_o === 1'b1) begin
        vectors++;
        got = (sb_q.size() != 0) ? sb_q.pop_front() : e;
        if (cpu_rdata_o !== got.rdata || cpu_err_o !== got.err) begin
          miscompares++;
          $display("FAIL b2b_data: got rdata=%h err=%b want %h %b", cpu_rdata_o, cpu_err_o, got.rdata, got.err);
        end
        if (last_rv >= 0) begin
          vectors++;
          if (c - last_rv != 3) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d cycles want 3", c - last_rv);
          end
        end
        last_rv = c;
        rvs++;
      end
      if (cpu_ready_o === 1'b1 && cpu_req_i === 1'b1) begin
        pending = 1'b1;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    cpu_req_i = 1'b0;
    vectors++;
    if (rvs != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d completions want 3", rvs);
    end
  endtask

  task automatic test_reset_mid();
    int rv0;
    @(negedge clk);
    resp_delay = -1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h8000_0208;
    cpu_be_i = 4'hF;
    cpu_req_i = 1'b1;
    @(negedge clk);
    cpu_req_i = 1'b0;
    vectors++;
    if ({pbus.peri_req, pbus.gpio_c_sel} !== 2'b11) begin
      miscompares++;
      $display("FAIL rstmid_req: got req/selC %b want 11", {pbus.peri_req, pbus.gpio_c_sel});
    end
    @(negedge clk);
    @(negedge clk);
    rv0 = rv_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({pbus.peri_req, pbus.gpio_c_sel, cpu_ready_o, cpu_rvalid_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL rstmid_drop: got req/selC/ready/rvalid %b want 0010",
               {pbus.peri_req, pbus.gpio_c_sel, cpu_ready_o, cpu_rvalid_o});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rv_count != rv0) begin
      miscompares++;
      $display("FAIL rstmid_no_rvalid: got %0d completions want 0", rv_count - rv0);
    end
    run_access(1'b0, 32'h8000_0208, 32'h0, 4'hF, 1, 32'hC0C0_0208, 1'b0);
  endtask

  task automatic test_spurious_ack();
    int          rv0;
    logic [31:0] rd0;
    @(negedge clk);
    rv0 = rv_count;
    rd0 = cpu_rdata_o;
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (cpu_rvalid_o !== 1'b0 || cpu_ready_o !== 1'b1 || cpu_rdata_o !== rd0) begin
        miscompares++;
        $display("FAIL spurious_idle: got rvalid=%b ready=%b rdata=%h want 0 1 %h",
                 cpu_rvalid_o, cpu_ready_o, cpu_rdata_o, rd0);
      end
    end
    spurious = 1'b0;
    @(negedge clk);
    run_access(1'b0, 32'h8000_0310, 32'h0, 4'hF, 4, 32'h0000_5A5A, 1'b1);
    repeat (2) @(negedge clk);
    vectors++;
    if (rv_count != rv0 + 1) begin
      miscompares++;
      $display("FAIL one_completion: got %0d completions want 1", rv_count - rv0);
    end
  endtask

  task automatic test_timeout();
`ifdef DBUS_TIMEOUT_EN
    run_access(1'b0, 32'h8000_0020, 32'h0, 4'hF, -1, 32'hFFFF_0000, 1'b0);
`endif
    run_access(1'b0, 32'h8000_0010, 32'h0, 4'hF, TIMEOUT_CYCLES, 32'hC0DE_0016, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_gpiob();
    test_store_gpled();
    test_decode_miss();
    test_all_selects();
    test_back_to_back();
    test_reset_mid();
    test_spurious_ack();
    test_timeout();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
